// File: rtl/pb_i2c_arbiter.sv
`timescale 1ns / 1ps
// pb_i2c_arbiter
//   Shares the power-board I2C transaction engine between the host command path and an
//   autonomous poller. The poller sweeps POLL_COUNT single-byte reads (type 2) of consecutive
//   registers once per POLL_PERIOD tick. One transaction runs at a time, operands are held
//   stable from issue to completion, and a watchdog aborts a transaction that runs too long.
// Ports
//   clk, n_reset                      clock, asynchronous active-low reset
//   host_req/type/addr/reg/wr0/wr1    host request (level) and operands
//   host_ack, host_done, host_err     request latched / finished / finished with timeout
//   host_rd0/1                        read data, updated on host_done
//   poll_en                           enables the tick counter and sweeps
//   poll_valid/idx/data/err           one pulse per completed poll read
//   poll_overrun                      tick arrived while a sweep was still pending
//   eng_*                             engine start, operands, status and read data
//   busy                              arbiter not idle
module pb_i2c_arbiter #(
  parameter int unsigned POLL_PERIOD    = 32'd1_000_000,
  parameter int unsigned POLL_COUNT     = 4,
  parameter logic [7:0]  POLL_ADDR      = 8'h6C,
  parameter logic [7:0]  POLL_REG_BASE  = 8'h00,
  parameter int unsigned TIMEOUT_CYCLES = 32'd200_000
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       host_req,
  input  logic [3:0] host_type,
  input  logic [7:0] host_addr,
  input  logic [7:0] host_reg,
  input  logic [7:0] host_wr0,
  input  logic [7:0] host_wr1,
  output logic       host_ack,
  output logic       host_done,
  output logic       host_err,
  output logic [7:0] host_rd0,
  output logic [7:0] host_rd1,
  input  logic       poll_en,
  output logic       poll_valid,
  output logic [3:0] poll_idx,
  output logic [7:0] poll_data,
  output logic       poll_err,
  output logic       poll_overrun,
  output logic [3:0] eng_type,
  output logic       eng_start,
  input  logic       eng_status,
  output logic [7:0] eng_addr,
  output logic [7:0] eng_reg,
  output logic [7:0] eng_wr0,
  output logic [7:0] eng_wr1,
  input  logic [7:0] eng_rd0,
  input  logic [7:0] eng_rd1,
  output logic       busy
);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitBusy,
    StWaitDone,
    StComplete,
    StDrain
  } state_e;

  state_e      state_q;
  logic [31:0] tick_q;
  logic [31:0] wdog_q;
  logic        sweep_q;
  logic [3:0]  idx_q;
  logic        last_poll_q;   // owner of the previous grant was the poller
  logic        owner_poll_q;  // owner of the current transaction is the poller

  logic tick_wrap, timeout, poll_last, poll_req, grant_poll;
  logic done_ok, to_hit, report;

  assign tick_wrap  = poll_en && (tick_q == 32'(POLL_PERIOD - 1));
  assign timeout    = wdog_q >= 32'(TIMEOUT_CYCLES - 1);
  assign poll_last  = idx_q == 4'(POLL_COUNT - 1);
  assign poll_req   = sweep_q && poll_en;
  // With both requesting, the poller wins only if the host owned the previous transaction.
  assign grant_poll = poll_req && !(host_req && last_poll_q);

  assign done_ok = (state_q == StWaitDone) && !eng_status;
  // A normal completion in the same cycle as the timeout takes precedence.
  assign to_hit  = timeout && ((state_q == StWaitBusy) ||
                               ((state_q == StWaitDone) && eng_status));
  assign report  = done_ok || to_hit;

  assign busy = state_q != StIdle;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q      <= StIdle;
      tick_q       <= '0;
      wdog_q       <= '0;
      sweep_q      <= 1'b0;
      idx_q        <= '0;
      last_poll_q  <= 1'b0;
      owner_poll_q <= 1'b0;
      host_ack     <= 1'b0;
      host_done    <= 1'b0;
      host_err     <= 1'b0;
      host_rd0     <= '0;
      host_rd1     <= '0;
      poll_valid   <= 1'b0;
      poll_idx     <= '0;
      poll_data    <= '0;
      poll_err     <= 1'b0;
      poll_overrun <= 1'b0;
      eng_type     <= '0;
      eng_start    <= 1'b0;
      eng_addr     <= '0;
      eng_reg      <= '0;
      eng_wr0      <= '0;
      eng_wr1      <= '0;
    end else begin
      eng_start    <= 1'b0;
      host_ack     <= 1'b0;
      host_done    <= 1'b0;
      poll_valid   <= 1'b0;
      poll_overrun <= 1'b0;

      if (!poll_en || tick_wrap) begin
        tick_q <= '0;
      end else begin
        tick_q <= tick_q + 32'd1;
      end

      // A poll transaction in flight keeps its index until it reports.
      if (!poll_en && ((state_q == StIdle) || !owner_poll_q)) begin
        sweep_q <= 1'b0;
        idx_q   <= '0;
      end

      unique case (state_q)
        StIdle: begin
          if (host_req || poll_req) begin
            owner_poll_q <= grant_poll;
            last_poll_q  <= grant_poll;
            if (grant_poll) begin
              eng_type <= 4'd2;
              eng_addr <= POLL_ADDR;
              eng_reg  <= POLL_REG_BASE + {4'd0, idx_q};
              eng_wr0  <= 8'h00;
              eng_wr1  <= 8'h00;
            end else begin
              eng_type <= host_type;
              eng_addr <= host_addr;
              eng_reg  <= host_reg;
              eng_wr0  <= host_wr0;
              eng_wr1  <= host_wr1;
            end
            eng_start <= 1'b1;
            host_ack  <= !grant_poll;
            wdog_q    <= '0;
            state_q   <= StIssue;
          end
        end
        StIssue: begin
          wdog_q  <= wdog_q + 32'd1;
          state_q <= StWaitBusy;
        end
        StWaitBusy: begin
          wdog_q <= wdog_q + 32'd1;
          if (to_hit) begin
            state_q <= StDrain;
          end else if (eng_status) begin
            state_q <= StWaitDone;
          end
        end
        StWaitDone: begin
          wdog_q <= wdog_q + 32'd1;
          if (done_ok) begin
            state_q <= StComplete;
          end else if (to_hit) begin
            state_q <= StDrain;
          end
        end
        StComplete: begin
          state_q <= StIdle;
        end
        StDrain: begin
          // Never start a new transaction while the engine is still busy.
          if (!eng_status) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase

      if (report) begin
        if (owner_poll_q) begin
          poll_valid <= 1'b1;
          poll_idx   <= idx_q;
          poll_err   <= to_hit;
          poll_data  <= to_hit ? 8'h00 : eng_rd0;
          if (poll_last || !poll_en) begin
            idx_q   <= '0;
            sweep_q <= 1'b0;
          end else begin
            idx_q <= idx_q + 4'd1;
          end
        end else begin
          host_done <= 1'b1;
          host_err  <= to_hit;
          host_rd0  <= to_hit ? 8'h00 : eng_rd0;
          host_rd1  <= to_hit ? 8'h00 : eng_rd1;
        end
      end

      // A tick while a sweep is pending is reported and dropped.
      if (tick_wrap) begin
        if (sweep_q) begin
          poll_overrun <= 1'b1;
        end else begin
          sweep_q <= 1'b1;
        end
      end
    end
  end

endmodule
